// File: rtl/prio_scan_enc.sv
// prio_scan_enc: latches a request vector and emits the index of each set bit, one beat per bit, in priority order.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   d, in_valid, in_ready: input vector handshake, accepted only in IDLE
//   y, out_valid,        : output beat stream; y is the current set-bit index,
//   out_ready, out_last  : out_last marks the final beat of the vector
//   none                 : beat produced for an all-zero vector (y=0, out_last=1)
//   cnt                  : popcount of the accepted vector, present only with PRIO_SCAN_CNT_EN
module prio_scan_enc #(
    parameter int WIDTH = 16,
    parameter bit LSB_FIRST = 1'b0,
    localparam int IDXW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             in_valid,
    output logic             in_ready,
`ifdef PRIO_SCAN_CNT_EN
    output logic [IDXW:0]    cnt,
`endif
    output logic [IDXW-1:0]  y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             none
);
    typedef enum logic {IDLE, SCAN} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic none_q, none_d;
    logic [IDXW-1:0] sel;
    logic single, accept, take;
    // Later matches overwrite earlier ones, so loop direction sets the priority.
    always_comb begin
        sel = '0;
        if (LSB_FIRST) begin
            for (int i = WIDTH - 1; i >= 0; i--) if (rem_q[i]) sel = IDXW'(i);
        end else begin
            for (int i = 0; i < WIDTH; i++) if (rem_q[i]) sel = IDXW'(i);
        end
    end
    assign single    = (rem_q != '0) && ((rem_q & (rem_q - WIDTH'(1))) == '0);
    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == SCAN;
    assign y         = sel;
    assign out_last  = out_valid && (single || none_q);
    assign none      = none_q;
    assign accept    = in_ready && in_valid;
    assign take      = out_valid && out_ready;
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        none_d  = none_q;
        if (accept) begin
            rem_d   = d;
            none_d  = d == '0;
            state_d = SCAN;
        end else if (take) begin
            rem_d[sel] = 1'b0;
            if (out_last) begin
                state_d = IDLE;
                none_d  = 1'b0;
            end
        end
    end
`ifdef PRIO_SCAN_CNT_EN
    logic [IDXW:0] cnt_q, cnt_d, pop;
    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) pop = pop + (IDXW+1)'(d[i]);
    end
    assign cnt_d = accept ? pop : cnt_q;
    assign cnt   = cnt_q;
    always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            none_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            none_q  <= none_d;
        end
    end
endmodule

// File: doc/prio_scan_enc.md
PRIO_SCAN_ENC -- requirements
Module: prio_scan_enc

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the width of the input request vector (>=2).
REQ-002 Parameter LSB_FIRST, default 0, SHALL select scan order: 0 = highest index first, 1 = lowest index first.
REQ-003 Localparam IDXW SHALL equal $clog2(WIDTH) and is not user-settable.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-006 d  input  WIDTH  SHALL carry the request vector, sampled on accept.
REQ-007 in_valid  input  1  SHALL indicate d is valid.
REQ-008 in_ready  output  1  SHALL indicate the block can accept a vector.
REQ-009 y  output  IDXW  SHALL carry the encoded index of the current set bit.
REQ-010 out_valid  output  1  SHALL indicate y, out_last and none are valid.
REQ-011 out_ready  input  1  SHALL indicate the consumer takes the current beat.
REQ-012 out_last  output  1  SHALL mark the final beat for the accepted vector.
REQ-013 none  output  1  SHALL mark a beat produced for an all-zero vector.

Function
REQ-014 The FSM SHALL have states IDLE and SCAN; in_ready SHALL be 1 only in IDLE.
REQ-015 Accept: in_valid && in_ready at an edge SHALL load d into internal register rem and move to SCAN.
REQ-016 out_valid SHALL rise in the cycle after accept (latency 1) and remain 1 throughout SCAN.
REQ-017 In SCAN, y SHALL be the index of the highest (LSB_FIRST=0) or lowest (LSB_FIRST=1) set bit of rem.
REQ-018 On out_valid && out_ready, the bit at y SHALL be cleared in rem at that edge.
REQ-019 out_last SHALL be 1 when rem has exactly one set bit, or when none=1.
REQ-020 The beat with out_last=1 SHALL, when taken, return the FSM to IDLE; in_ready SHALL be 1 in the following cycle.
REQ-021 If the accepted d is zero, the block SHALL emit exactly one beat with none=1, out_last=1, y=0.
REQ-022 While out_valid=1 and out_ready=0, y, out_last, none and rem SHALL hold unchanged.
REQ-023 in_valid while not in IDLE SHALL be ignored, with no state change.
REQ-024 A vector with k set bits (k>=1) SHALL produce exactly k beats, each index once, in strict scan order.
REQ-025 Outputs SHALL be driven from registered state only, with no combinational path from d or in_valid to any output.

Reset
REQ-026 With rst=1 at an edge, the FSM SHALL enter IDLE and clear rem, regardless of state or other inputs.
REQ-027 The post-reset output values SHALL be: in_ready=1, out_valid=0, y=0, out_last=0, none=0, cnt=0.
REQ-028 Reset asserted mid-scan SHALL discard the remaining bits; no further beat for that vector SHALL appear.

Configuration
REQ-029 Macro PRIO_SCAN_CNT_EN, when defined, SHALL add output cnt (width IDXW+1) carrying the popcount of the vector latched at accept.
REQ-030 cnt SHALL be constant on every beat of a vector and SHALL be 0 for an all-zero vector.
REQ-031 Without PRIO_SCAN_CNT_EN, the cnt port and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-032 WIDTH=16, LSB_FIRST=0, d=16'h8001, out_ready=1 -> beats y=15 (last=0), then y=0 (last=1); in_ready=1 the next cycle.
REQ-033 d=16'h0000 -> one beat with none=1, out_last=1, y=0; then IDLE.
REQ-034 d=16'h0030, out_ready held 0 for 3 cycles -> y stays 5 for those cycles, then y=5 and y=4 (last) once out_ready=1.
REQ-035 LSB_FIRST=1, d=16'hFFFF, out_ready=1 -> 16 consecutive beats y=0..15, out_last only on y=15; in_valid pulses during the scan are ignored.
REQ-036 d=16'h00F0, rst=1 after first beat (y=7) -> next cycle out_valid=0, in_ready=1, no beat y=6.
REQ-037 With PRIO_SCAN_CNT_EN defined, d=16'hA5A5 -> cnt=8 on all 8 beats; for d=0, cnt=0.
